// File: rtl/prim_assembler.sv
// Purpose: groups ID-stage vertex commands into point/line/triangle primitives for the rasterizer.
// Latency: primitive is valid the cycle after its completing vertex is consumed; Draw_Out likewise one cycle after Draw.
// Backpressure: single-entry output register; Stall = Prim_Valid & ~Prim_Ready holds the ID stage and blocks all input consumption.
module prim_assembler #(
  parameter int VERTEX_WIDTH = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    StartPrimitive,
  input  logic [3:0]              PrimitiveType,
  input  logic                    NewVertex,
  input  logic [VERTEX_WIDTH-1:0] Vertex,
  input  logic                    EndPrimitive,
  input  logic                    Draw,
  output logic                    Stall,
  output logic                    Prim_Valid,
  input  logic                    Prim_Ready,
  output logic [3:0]              Prim_Type,
  output logic [VERTEX_WIDTH-1:0] Prim_V0,
  output logic [VERTEX_WIDTH-1:0] Prim_V1,
  output logic [VERTEX_WIDTH-1:0] Prim_V2,
  output logic                    Draw_Out,
  output logic [CNT_WIDTH-1:0]    Prim_Count,
  output logic                    Err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;

  localparam logic [3:0] T_POINT     = 4'd0;
  localparam logic [3:0] T_LINE      = 4'd1;
  localparam logic [3:0] T_TRIANGLE  = 4'd2;
  localparam logic [3:0] T_TRI_STRIP = 4'd3;
  localparam logic [3:0] T_TRI_FAN   = 4'd4;

  state_t                  state_q, state_d;
  logic [3:0]              type_q, type_d;
  logic [1:0]              vcnt_q, vcnt_d;
  logic                    parity_q, parity_d;
  logic [VERTEX_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic                    err_d, draw_d;

  logic                    emit;
  logic [VERTEX_WIDTH-1:0] e_v0, e_v1, e_v2;

  logic take, start_ev, end_ev, nv_ev, draw_ev, multi;

  // Stall only reflects the output register, never the ID inputs.
  assign Stall = Prim_Valid & ~Prim_Ready;
  assign take  = ~Stall;

  // Priority decode: Start > End > NewVertex > Draw.
  assign start_ev = StartPrimitive;
  assign end_ev   = ~StartPrimitive & EndPrimitive;
  assign nv_ev    = ~StartPrimitive & ~EndPrimitive & NewVertex;
  assign draw_ev  = ~StartPrimitive & ~EndPrimitive & ~NewVertex & Draw;
  assign multi    = (StartPrimitive & (EndPrimitive | NewVertex | Draw)) |
                    (EndPrimitive & (NewVertex | Draw)) |
                    (NewVertex & Draw);

  // Next-state, vertex buffer update and primitive emission for the consumed command.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    vcnt_d   = vcnt_q;
    parity_d = parity_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    err_d    = Err;
    draw_d   = 1'b0;
    emit     = 1'b0;
    e_v0     = '0;
    e_v1     = '0;
    e_v2     = '0;
    if (take) begin
      if (multi) err_d = 1'b1;
      if (start_ev) begin
        // A start while collecting implicitly ends the current primitive.
        vcnt_d   = 2'd0;
        parity_d = 1'b0;
        if (PrimitiveType <= T_TRI_FAN) begin
          state_d = ST_COLLECT;
          type_d  = PrimitiveType;
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end else if (end_ev) begin
        // Partial vertices are simply dropped.
        state_d = ST_IDLE;
        vcnt_d  = 2'd0;
      end else if (nv_ev) begin
        if (state_q == ST_IDLE) begin
          err_d = 1'b1;
        end else begin
          unique case (type_q)
            T_POINT: begin
              emit = 1'b1;
              e_v0 = Vertex;
            end
            T_LINE: begin
              if (vcnt_q == 2'd0) begin
                s0_d   = Vertex;
                vcnt_d = 2'd1;
              end else begin
                emit   = 1'b1;
                e_v0   = s0_q;
                e_v1   = Vertex;
                vcnt_d = 2'd0;
              end
            end
            T_TRIANGLE: begin
              if (vcnt_q == 2'd0) begin
                s0_d   = Vertex;
                vcnt_d = 2'd1;
              end else if (vcnt_q == 2'd1) begin
                s1_d   = Vertex;
                vcnt_d = 2'd2;
              end else begin
                emit   = 1'b1;
                e_v0   = s0_q;
                e_v1   = s1_q;
                e_v2   = Vertex;
                vcnt_d = 2'd0;
              end
            end
            T_TRI_STRIP, T_TRI_FAN: begin
              if (vcnt_q == 2'd0) begin
                s0_d   = Vertex;
                vcnt_d = 2'd1;
              end else if (vcnt_q == 2'd1) begin
                s1_d   = Vertex;
                vcnt_d = 2'd2;
              end else begin
                emit   = 1'b1;
                e_v2   = Vertex;
                vcnt_d = 2'd3;
                s1_d   = Vertex;
                if (type_q == T_TRI_STRIP) begin
                  // Odd strip triangles swap the first two vertices to keep winding order.
                  e_v0     = parity_q ? s1_q : s0_q;
                  e_v1     = parity_q ? s0_q : s1_q;
                  s0_d     = s1_q;
                  parity_d = ~parity_q;
                end else begin
                  // Fan keeps the first vertex in S0 forever.
                  e_v0 = s0_q;
                  e_v1 = s1_q;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end else if (draw_ev) begin
        draw_d = 1'b1;
      end
    end
  end

  // FSM state and vertex buffer registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      type_q   <= 4'd0;
      vcnt_q   <= 2'd0;
      parity_q <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      vcnt_q   <= vcnt_d;
      parity_q <= parity_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
    end
  end

  // Single-entry output register: load on emit, clear on handshake, hold otherwise.
  // Prim_Type reports the primitive type as latched at StartPrimitive.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Prim_Valid <= 1'b0;
      Prim_Type  <= 4'd0;
      Prim_V0    <= '0;
      Prim_V1    <= '0;
      Prim_V2    <= '0;
    end else if (emit) begin
      Prim_Valid <= 1'b1;
      Prim_Type  <= type_q;
      Prim_V0    <= e_v0;
      Prim_V1    <= e_v1;
      Prim_V2    <= e_v2;
    end else if (Prim_Valid && Prim_Ready) begin
      Prim_Valid <= 1'b0;
    end
  end

  // Accepted-primitive counter, sticky error flag and draw pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Prim_Count <= '0;
      Err        <= 1'b0;
      Draw_Out   <= 1'b0;
    end else begin
      if (Prim_Valid && Prim_Ready) Prim_Count <= Prim_Count + 1'b1;
      Err      <= err_d;
      Draw_Out <= draw_d;
    end
  end

endmodule
